// File: rtl/ulpi_reg_sequencer.sv
// ULPI register-port master: boots the PHY (vendor ID check, Function Control write),
// then round-robin arbitrates single register accesses from two requesters with a timeout.
module ulpi_reg_sequencer #(
    parameter logic [15:0] VENDOR_ID      = 16'h0424,
    parameter logic [7:0]  FUNC_CTRL_INIT = 8'h41,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [7:0]  addr0_i,
    input  logic [7:0]  addr1_i,
    input  logic [7:0]  wdata0_i,
    input  logic [7:0]  wdata1_i,
    output logic [7:0]  rdata_o,
    output logic [1:0]  ack_o,
    output logic [1:0]  err_o,
    output logic [7:0]  reg_addr_o,
    output logic        reg_stb_o,
    output logic        reg_we_o,
    output logic [7:0]  reg_data_o,
    input  logic [7:0]  reg_data_i,
    input  logic        reg_ack_i,
    output logic        boot_done_o,
    output logic        id_ok_o,
    output logic [15:0] vendor_id_o
);

    typedef enum logic [2:0] {
        B_RDLO = 3'd0,
        B_RDHI = 3'd1,
        B_WRFC = 3'd2,
        IDLE   = 3'd3,
        GRANT  = 3'd4
    } state_t;

    localparam logic [8:0] TMO_LAST = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        stb_q, stb_d, we_q, we_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
    logic        ptr_q, ptr_d, gnt_q, gnt_d;
    logic [1:0]  ack_q, ack_d, err_q, err_d;
    logic        boot_done_q, boot_done_d, id_ok_q, id_ok_d, boot_err_q, boot_err_d;
    logic [15:0] vid_q, vid_d;
    logic        tmo_s, done_s, g_s;

    // Completion and timeout detection for the access currently on the bus
    always_comb begin
        tmo_s  = stb_q && !reg_ack_i && (({1'b0, cnt_q} + 9'd1) == TMO_LAST);
        done_s = stb_q && (reg_ack_i || tmo_s);
        g_s    = req_i[ptr_q] ? ptr_q : ~ptr_q;
    end

    // Next-state and output logic: stb only rises from a state where it is low,
    // so every access is preceded by at least one stb=0 cycle with addr/we/data set up.
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        rdata_d     = 8'h00;
        boot_done_d = boot_done_q;
        id_ok_d     = id_ok_q;
        boot_err_d  = boot_err_q;
        vid_d       = vid_q;
        if (stb_q && !done_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'h00;
        end

        case (state_q)
            B_RDLO: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (done_s) begin
                    stb_d = 1'b0;
                    if (reg_ack_i) begin
                        vid_d[7:0] = reg_data_i;
                    end else begin
                        boot_err_d = 1'b1;
                    end
                    addr_d  = 8'h01;
                    state_d = B_RDHI;
                end else begin
                    stb_d = 1'b1;
                end
            end
            B_RDHI: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (done_s) begin
                    stb_d = 1'b0;
                    if (reg_ack_i) begin
                        vid_d[15:8] = reg_data_i;
                    end else begin
                        boot_err_d = 1'b1;
                    end
                    addr_d  = 8'h04;
                    we_d    = 1'b1;
                    wdata_d = FUNC_CTRL_INIT;
                    state_d = B_WRFC;
                end else begin
                    stb_d = 1'b1;
                end
            end
            B_WRFC: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (done_s) begin
                    stb_d       = 1'b0;
                    boot_err_d  = boot_err_q || tmo_s;
                    boot_done_d = 1'b1;
                    id_ok_d     = (vid_q == VENDOR_ID) && !(boot_err_q || tmo_s);
                    addr_d      = 8'h00;
                    we_d        = 1'b0;
                    wdata_d     = 8'h00;
                    state_d     = IDLE;
                end else begin
                    stb_d = 1'b1;
                end
            end
            IDLE: begin
                stb_d = 1'b0;
                if (boot_done_q && (req_i != 2'b00)) begin
                    gnt_d   = g_s;
                    we_d    = we_i[g_s];
                    addr_d  = g_s ? addr1_i : addr0_i;
                    wdata_d = g_s ? wdata1_i : wdata0_i;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (done_s) begin
                    stb_d = 1'b0;
                    if (reg_ack_i) begin
                        ack_d   = gnt_q ? 2'b10 : 2'b01;
                        rdata_d = we_q ? 8'h00 : reg_data_i;
                    end else begin
                        err_d = gnt_q ? 2'b10 : 2'b01;
                    end
                    ptr_d   = ~gnt_q;
                    state_d = IDLE;
                end else begin
                    stb_d = 1'b1;
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = B_RDLO;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= B_RDLO;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            cnt_q       <= 8'h00;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            boot_done_q <= 1'b0;
            id_ok_q     <= 1'b0;
            boot_err_q  <= 1'b0;
            vid_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            boot_done_q <= boot_done_d;
            id_ok_q     <= id_ok_d;
            boot_err_q  <= boot_err_d;
            vid_q       <= vid_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign reg_addr_o  = addr_q;
    assign reg_stb_o   = stb_q;
    assign reg_we_o    = we_q;
    assign reg_data_o  = wdata_q;
    assign boot_done_o = boot_done_q;
    assign id_ok_o     = id_ok_q;
    assign vendor_id_o = vid_q;

endmodule
